fifo_byte_serializer: RTL and testbench
=======================================

# fifo_byte_serializer

Downstream drain stage for the `fifo` block. Pops `bitWidth`-bit words from the FIFO's first-word-fall-through read side and emits them as a stream of `byteWidth`-bit beats over a valid/ready handshake, with a per-word last flag. Sustains one beat per cycle with no bubble between words while the FIFO holds data and the sink is ready.

## Interface

Parameters:
- `bitWidth`, 32, FIFO word width; must be an integer multiple of `byteWidth`.
- `byteWidth`, 8, output beat width.
- `msbFirst`, 1, 1 = most-significant beat emitted first, 0 = least-significant first.

Derived: `nrOfBeats = bitWidth/byteWidth` (≥2); beat index width `idxW = clog2(nrOfBeats)`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `fifoEmpty`  in  1  FIFO empty flag.
- `fifoPopData`  in  bitWidth  FIFO head word; valid whenever `fifoEmpty`=0.
- `fifoPop`  out  1  pop strobe to FIFO; one pulse per word consumed.
- `byteData`  out  byteWidth  current beat.
- `byteValid`  out  1  beat valid.
- `byteReady`  in  1  sink accepts beat.
- `byteLast`  out  1  high with the final beat of each word.
- `busy`  out  1  high while a word is held (state SHIFT).
- `wordCount`  out  16  number of words fully emitted; wraps 0xFFFF→0x0000.

## Operation

- Internal registers: state (IDLE, SHIFT), shift register `bitWidth`, beat index `idxW`, `wordCount`.
- Beat transfer = `byteValid && byteReady` at a rising edge.
- IDLE: `byteValid`=0. If `fifoEmpty`=0: `fifoPop`=1 this cycle; at the edge, `fifoPopData` loads into the shift register, index←0, state←SHIFT.
- SHIFT: `byteValid`=1; `byteData` = upper `byteWidth` bits of the shift register (`msbFirst`=1) or lower bits (`msbFirst`=0); `byteLast` = (index == nrOfBeats-1).
  - Transfer, not last: shift register shifts by `byteWidth` toward the output end; index+1.
  - Transfer, last: `wordCount`+1; if `fifoEmpty`=0, `fifoPop`=1 the same cycle, next word loads, index←0, stay SHIFT (no bubble); otherwise state←IDLE.
  - No transfer: all registers hold; `byteData`/`byteLast` stable.
- `fifoPop` is combinational: (IDLE && !fifoEmpty) || (SHIFT && byteValid && byteReady && byteLast && !fifoEmpty). Never asserted while `fifoEmpty`=1.
- `busy` = (state == SHIFT).

## Timing

- Reset (`reset`=0, asynchronous): state IDLE, shift register 0, index 0, `wordCount` 0; outputs `byteValid`=0, `byteData`=0, `byteLast`=0, `busy`=0, `fifoPop`=0 (forced 0 while reset asserted regardless of `fifoEmpty`). Deassertion takes effect at the next rising edge.
- Reset mid-word: partially emitted word is discarded; no further beats; `wordCount` cleared; the FIFO is not re-popped for that word.
- Latency: `fifoEmpty` falls in IDLE before edge k → pop at edge k → first beat valid from edge k through at least edge k+1.
- Throughput: `nrOfBeats` cycles per word with `byteReady` held 1 and FIFO non-empty; `fifoPop` pulses exactly once every `nrOfBeats` cycles.
- `byteValid` never drops without a transfer (no retraction once asserted); `byteData` changes only after a transfer.
- `fifoEmpty` rising during a word has no effect until the last-beat transfer.
- `byteReady` is sampled only while `byteValid`=1; ready in IDLE has no effect.

## Test plan

- Single word, defaults: push 0x11223344, `byteReady`=1 → beats 0x11,0x22,0x33,0x44 on consecutive cycles, `byteLast` only on 0x44, one `fifoPop` pulse, `wordCount`=1, return to IDLE with `byteValid`=0.
- Back-to-back: FIFO preloaded with 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3, `byteReady`=1 → 12 consecutive beats with no gap; `fifoPop` high exactly on cycles 0, 4, 8; `wordCount`=3.
- Backpressure: 0xDEADBEEF, `byteReady` toggling 1,0,0,1,0,1,1 → `byteData` holds 0xAD across the stalled cycles; sequence DE,AD,BE,EF unchanged; `byteLast` held with EF until accepted.
- `msbFirst`=0: word 0x11223344 → beats 0x44,0x33,0x22,0x11; `byteLast` on 0x11.
- Empty guard and reset: FIFO empty for 20 cycles → `fifoPop`=0, `byteValid`=0 throughout; then push 0x01020304, assert `reset`=0 after the 2nd beat → all outputs 0 immediately (asynchronously), `wordCount`=0, no further `fifoPop` while reset held.
- Counter wrap: preset by emitting 65536 words → `wordCount` reads 0x0000 after the final word.

Source files
------------

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: drains words from a first-word-fall-through FIFO and
// emits them as byteWidth-bit beats over valid/ready, with a per-word last flag.
// Back-to-back words are chained on the last-beat transfer, so there is no bubble.
module fifo_byte_serializer #(
  parameter int unsigned bitWidth  = 32,
  parameter int unsigned byteWidth = 8,
  parameter bit          msbFirst  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fifoEmpty,
  input  logic [bitWidth-1:0]  fifoPopData,
  output logic                 fifoPop,
  output logic [byteWidth-1:0] byteData,
  output logic                 byteValid,
  input  logic                 byteReady,
  output logic                 byteLast,
  output logic                 busy,
  output logic [15:0]          wordCount
);

  localparam int unsigned NrOfBeats = bitWidth / byteWidth;
  localparam int unsigned IdxW      = (NrOfBeats > 1) ? $clog2(NrOfBeats) : 1;
  localparam int unsigned LastIdx   = NrOfBeats - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q;
  logic [bitWidth-1:0]  shift_q;
  logic [IdxW-1:0]      idx_q;
  logic [15:0]          word_cnt_q;
  logic                 xfer;

  // Output decode from the state/shift/index registers plus the pop strobe
  always_comb begin
    byteValid = (state_q == SHIFT);
    busy      = (state_q == SHIFT);
    byteLast  = (state_q == SHIFT) && (idx_q == IdxW'(LastIdx));
    byteData  = msbFirst ? shift_q[bitWidth-1 -: byteWidth] : shift_q[byteWidth-1:0];
    xfer      = byteValid && byteReady;
    // Reset gates the pop so the FIFO is never drained while the block is held
    fifoPop   = reset && !fifoEmpty && ((state_q == IDLE) || (xfer && byteLast));
    wordCount = word_cnt_q;
  end

  // Load/shift FSM: IDLE waits for data, SHIFT walks the beats of the held word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifoPop) begin
            shift_q <= fifoPopData;
            idx_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (byteLast) begin
              word_cnt_q <= word_cnt_q + 16'd1;
              if (fifoPop) begin
                shift_q <= fifoPopData;
                idx_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              shift_q <= msbFirst ? (shift_q << byteWidth) : (shift_q >> byteWidth);
              idx_q   <= idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Scoreboard bench for fifo_byte_serializer: a FIFO model feeds the DUT,
// directed stimulus pushes hand-computed beats into an expect queue, and
// negedge monitors pop and compare on every accepted beat.
module tb_fifo_byte_serializer;

  logic        clock;
  logic        reset;
  logic        fifoEmpty;
  logic [31:0] fifoPopData;
  logic        fifoPop;
  logic [7:0]  byteData;
  logic        byteValid;
  logic        byteReady;
  logic        byteLast;
  logic        busy;
  logic [15:0] wordCount;

  // Second instance, LSB-first
  logic        fifoEmpty2;
  logic [31:0] fifoPopData2;
  logic        fifoPop2;
  logic [7:0]  byteData2;
  logic        byteValid2;
  logic        byteReady2;
  logic        byteLast2;
  logic        busy2;
  logic [15:0] wordCount2;

  int errors = 0;
  int nchecks = 0;
  int cyc = 0;
  int pop_cnt = 0;

  logic [31:0] fifo_q[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  exp2_q[$];
  int          pop_cyc[$];
  int          beat_cyc[$];

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = '0;
  logic        prev_last  = 1'b0;

  fifo_byte_serializer #(.bitWidth(32), .byteWidth(8), .msbFirst(1'b1)) dut (
    .clock(clock), .reset(reset), .fifoEmpty(fifoEmpty), .fifoPopData(fifoPopData),
    .fifoPop(fifoPop), .byteData(byteData), .byteValid(byteValid), .byteReady(byteReady),
    .byteLast(byteLast), .busy(busy), .wordCount(wordCount)
  );

  fifo_byte_serializer #(.bitWidth(32), .byteWidth(8), .msbFirst(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .fifoEmpty(fifoEmpty2), .fifoPopData(fifoPopData2),
    .fifoPop(fifoPop2), .byteData(byteData2), .byteValid(byteValid2), .byteReady(byteReady2),
    .byteLast(byteLast2), .busy(busy2), .wordCount(wordCount2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // FIFO model: head word presented while non-empty, popped on the DUT strobe
  always @(posedge clock) begin
    if (fifoPop && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
      fifoEmpty   <= (fifo_q.size() == 0);
      fifoPopData <= (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    end
  end

  // Single-word FIFO model for the LSB-first instance
  always @(posedge clock) begin
    if (fifoPop2) fifoEmpty2 <= 1'b1;
  end

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    fifoEmpty   = 1'b0;
    fifoPopData = fifo_q[0];
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Monitor for the MSB-first instance
  always @(negedge clock) begin
    logic [8:0] e;
    if (fifoPop) chk("pop_while_empty", {31'b0, fifoEmpty}, 32'h0);
    if (!reset) chk("pop_in_reset", {31'b0, fifoPop}, 32'h0);
    if (fifoPop) pop_cyc.push_back(cyc);
    if (prev_stall && reset) begin
      chk("hold_valid", {31'b0, byteValid}, 32'h1);
      chk("hold_data", {24'b0, byteData}, {24'b0, prev_data});
      chk("hold_last", {31'b0, byteLast}, {31'b0, prev_last});
    end
    if (reset && byteValid && byteReady) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {23'b0, byteLast, byteData}, 32'h1FF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", {24'b0, byteData}, {24'b0, e[7:0]});
        chk("beat_last", {31'b0, byteLast}, {31'b0, e[8]});
      end
    end
    prev_stall = reset && byteValid && !byteReady;
    prev_data  = byteData;
    prev_last  = byteLast;
  end

  // Monitor for the LSB-first instance
  always @(negedge clock) begin
    logic [8:0] e;
    if (reset && byteValid2 && byteReady2) begin
      if (exp2_q.size() == 0) begin
        chk("lsb_unexpected_beat", {23'b0, byteLast2, byteData2}, 32'h1FF);
      end else begin
        e = exp2_q.pop_front();
        chk("lsb_beat_data", {24'b0, byteData2}, {24'b0, e[7:0]});
        chk("lsb_beat_last", {31'b0, byteLast2}, {31'b0, e[8]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !byteValid) && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk(name, {31'b0, (n >= max_cyc)}, 32'h0);
  endtask

  initial begin
    int n;
    int viol;
    int pops0;
    logic [7:0] hold [7] = '{8'hDE, 8'hAD, 8'hAD, 8'hAD, 8'hBE, 8'hBE, 8'hEF};
    logic       lasts[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       pat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    reset        = 1'b0;
    fifoEmpty    = 1'b1;
    fifoPopData  = '0;
    byteReady    = 1'b0;
    fifoEmpty2   = 1'b1;
    fifoPopData2 = '0;
    byteReady2   = 1'b1;

    // Reset state
    #1;
    chk("rst_valid", {31'b0, byteValid}, 32'h0);
    chk("rst_data", {24'b0, byteData}, 32'h0);
    chk("rst_last", {31'b0, byteLast}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_pop", {31'b0, fifoPop}, 32'h0);
    chk("rst_count", {16'b0, wordCount}, 32'h0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // Single word, MSB first, with latency checks
    byteReady = 1'b1;
    push_word(32'h11223344);
    expect_beat(8'h11, 1'b0); expect_beat(8'h22, 1'b0);
    expect_beat(8'h33, 1'b0); expect_beat(8'h44, 1'b1);
    #1;
    chk("lat_pop", {31'b0, fifoPop}, 32'h1);
    tick(1);
    chk("lat_valid", {31'b0, byteValid}, 32'h1);
    chk("lat_data", {24'b0, byteData}, 32'h11);
    chk("lat_busy", {31'b0, busy}, 32'h1);
    wait_drain("drain_single", 20);
    chk("single_count", {16'b0, wordCount}, 32'h1);
    chk("single_pops", pop_cnt, 32'h1);
    chk("single_idle_valid", {31'b0, byteValid}, 32'h0);

    // Back-to-back words: no bubble, pops every 4 cycles
    tick(2);
    pop_cyc.delete();
    beat_cyc.delete();
    push_word(32'hA0A1A2A3); push_word(32'hB0B1B2B3); push_word(32'hC0C1C2C3);
    expect_beat(8'hA0, 1'b0); expect_beat(8'hA1, 1'b0); expect_beat(8'hA2, 1'b0); expect_beat(8'hA3, 1'b1);
    expect_beat(8'hB0, 1'b0); expect_beat(8'hB1, 1'b0); expect_beat(8'hB2, 1'b0); expect_beat(8'hB3, 1'b1);
    expect_beat(8'hC0, 1'b0); expect_beat(8'hC1, 1'b0); expect_beat(8'hC2, 1'b0); expect_beat(8'hC3, 1'b1);
    wait_drain("drain_b2b", 40);
    chk("b2b_pop_count", pop_cyc.size(), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_pop_gap1", pop_cyc[1] - pop_cyc[0], 32'd4);
      chk("b2b_pop_gap2", pop_cyc[2] - pop_cyc[1], 32'd4);
    end
    chk("b2b_beat_count", beat_cyc.size(), 32'd12);
    if (beat_cyc.size() == 12) chk("b2b_no_gap", beat_cyc[11] - beat_cyc[0], 32'd11);
    chk("b2b_count", {16'b0, wordCount}, 32'h4);

    // Backpressure with a fixed ready pattern
    tick(2);
    byteReady = 1'b0;
    push_word(32'hDEADBEEF);
    expect_beat(8'hDE, 1'b0); expect_beat(8'hAD, 1'b0);
    expect_beat(8'hBE, 1'b0); expect_beat(8'hEF, 1'b1);
    n = 0;
    while (!byteValid && n < 10) begin tick(1); n++; end
    chk("bp_valid_timeout", {31'b0, (n >= 10)}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      chk("bp_hold_data", {24'b0, byteData}, {24'b0, hold[i]});
      chk("bp_hold_last", {31'b0, byteLast}, {31'b0, lasts[i]});
      byteReady = pat[i];
      tick(1);
    end
    byteReady = 1'b1;
    chk("bp_idle_valid", {31'b0, byteValid}, 32'h0);
    wait_drain("drain_bp", 20);
    chk("bp_count", {16'b0, wordCount}, 32'h5);

    // LSB-first instance
    fifoPopData2 = 32'h11223344;
    exp2_q.push_back({1'b0, 8'h44}); exp2_q.push_back({1'b0, 8'h33});
    exp2_q.push_back({1'b0, 8'h22}); exp2_q.push_back({1'b1, 8'h11});
    fifoEmpty2 = 1'b0;
    n = 0;
    while (!(exp2_q.size() == 0 && !byteValid2 && fifoEmpty2) && n < 20) begin tick(1); n++; end
    chk("lsb_drain_timeout", {31'b0, (n >= 20)}, 32'h0);
    chk("lsb_count", {16'b0, wordCount2}, 32'h1);

    // Empty guard: nothing happens with the FIFO empty
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (fifoPop !== 1'b0 || byteValid !== 1'b0) viol++;
    end
    chk("empty_guard", viol, 32'h0);

    // Reset after the second beat of a word
    pops0 = pop_cnt;
    push_word(32'h01020304);
    expect_beat(8'h01, 1'b0); expect_beat(8'h02, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin tick(1); n++; end
    chk("rst_mid_timeout", {31'b0, (n >= 20)}, 32'h0);
    push_word(32'h0A0B0C0D);
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_valid", {31'b0, byteValid}, 32'h0);
    chk("rstmid_data", {24'b0, byteData}, 32'h0);
    chk("rstmid_last", {31'b0, byteLast}, 32'h0);
    chk("rstmid_busy", {31'b0, busy}, 32'h0);
    chk("rstmid_pop", {31'b0, fifoPop}, 32'h0);
    chk("rstmid_count", {16'b0, wordCount}, 32'h0);
    tick(5);
    chk("rsthold_valid", {31'b0, byteValid}, 32'h0);
    chk("rsthold_pops", pop_cnt - pops0, 32'h1);
    expect_beat(8'h0A, 1'b0); expect_beat(8'h0B, 1'b0);
    expect_beat(8'h0C, 1'b0); expect_beat(8'h0D, 1'b1);
    reset = 1'b1;
    wait_drain("drain_after_rst", 20);
    chk("after_rst_pops", pop_cnt - pops0, 32'h2);
    chk("after_rst_count", {16'b0, wordCount}, 32'h1);

    // Counter wrap from a preset near the top
    tick(1);
    force dut.word_cnt_q = 16'hFFFE;
    tick(1);
    release dut.word_cnt_q;
    tick(1);
    chk("wrap_preset", {16'b0, wordCount}, 32'hFFFE);
    push_word(32'h55667788);
    expect_beat(8'h55, 1'b0); expect_beat(8'h66, 1'b0);
    expect_beat(8'h77, 1'b0); expect_beat(8'h88, 1'b1);
    wait_drain("drain_wrap1", 20);
    chk("wrap_ffff", {16'b0, wordCount}, 32'hFFFF);
    push_word(32'h99AABBCC);
    expect_beat(8'h99, 1'b0); expect_beat(8'hAA, 1'b0);
    expect_beat(8'hBB, 1'b0); expect_beat(8'hCC, 1'b1);
    wait_drain("drain_wrap2", 20);
    chk("wrap_zero", {16'b0, wordCount}, 32'h0);
    chk("final_exp_empty", exp_q.size(), 32'h0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
